a2d_resp: RTL

SPI responder modelling the 8-channel, 12-bit A2D converter that the slide-pot interface polls through its SPI master. It sits on the same SS_n/SCLK/MOSI/MISO bus and decodes the 16-bit command frame to get a channel address. It returns that channel's conversion in the following frame, so the result is one frame pipelined. It is used as the converter in full-chip simulation and as the stand-in converter on FPGA builds without the real part. Channel values come from a parallel input bus driven by the bench or by on-board switches.

---
 rtl/a2d_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/a2d_resp.sv | 111 +++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared types and frame geometry for the A2D SPI responder model.
package a2d_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_MSB   = 13;
    localparam int ADDR_LSB   = 11;
    localparam int RES_W      = 12;
    localparam int PAD_W      = FRAME_BITS - RES_W;
    localparam int NUM_CH     = 8;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0] CNT_MAX   = 5'd31;
    localparam logic [CNT_W-1:0] FRAME_CNT = 5'd16;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, plus a delay flop for edge pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic ff1, ff2, ff3;

    // Reset to the pin's idle level so release of reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= RST_VAL;
            ff2 <= RST_VAL;
            ff3 <= RST_VAL;
        end else begin
            ff1 <= d;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    assign lvl  = ff2;
    assign rise = ff2 & ~ff3;
    assign fall = ~ff2 & ff3;

endmodule

// File: rtl/a2d_resp.sv
// SPI responder for an 8-channel 12-bit A2D: decodes a channel address from each
// 16-bit command frame and returns that channel's value in the following frame.
module a2d_resp
    import a2d_pkg::*;
#(
    parameter logic [2:0] RESET_ADDR = 3'd0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SS_n,
    input  logic                         SCLK,
    input  logic                         MOSI,
    output logic                         MISO,
    input  logic [NUM_CH-1:0][RES_W-1:0] ch_data,
    output logic                         frame_done,
    output logic                         frame_err,
    output logic [2:0]                   last_chnnl
);

    logic ss_lvl_unused, ss_rise, ss_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst_n(rst_n), .d(SS_n),
        .lvl(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(SCLK),
        .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d(MOSI),
        .lvl(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t                 state_q, state_d;
    logic [FRAME_BITS-1:0]  tx_q, tx_d;
    logic [FRAME_BITS-1:0]  rx_q, rx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             addr_q, addr_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= RESET_ADDR;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // ch_data is captured here only; later changes don't reach this frame.
                if (ss_fall) begin
                    tx_d    = {{PAD_W{1'b0}}, ch_data[addr_q]};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    if (cnt_q == FRAME_CNT) begin
                        addr_d = rx_q[ADDR_MSB:ADDR_LSB];
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[FRAME_BITS-2:0], mosi_s};
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    end
                    // The leading fall (before any rise) keeps the MSB on the wire.
                    if (sclk_fall && cnt_q != '0) tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign MISO       = (state_q == SHIFT) ? tx_q[FRAME_BITS-1] : 1'b0;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign last_chnnl = addr_q;

endmodule
